// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types, result encodings and saturating add for the perceptron trainer
package perceptron_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, UPDATE} state_t;

  localparam logic [1:0] RES_POS = 2'b01;
  localparam logic [1:0] RES_NEG = 2'b11;

  // Adds two signed values and clamps the sum to the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// rtl/perceptron_trainer_if.sv - sample/result handshake bundle between the IO mux and the trainer
interface perceptron_trainer_if #(
  parameter int N     = 7,
  parameter int ACC_W = 12,
  parameter int ERR_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0]            x;
  logic signed [ACC_W-1:0] threshold;
  logic                    exp_res;
  logic                    train_en;
  logic                    clear_w;
  logic                    out_valid;
  logic [1:0]              result;
  logic                    mispredict;
  logic [ERR_W-1:0]        err_count;

  modport master (
    output in_valid, x, threshold, exp_res, train_en, clear_w,
    input  in_ready, out_valid, result, mispredict, err_count
  );

  modport slave (
    input  in_valid, x, threshold, exp_res, train_en, clear_w,
    output in_ready, out_valid, result, mispredict, err_count
  );
endinterface

// File: rtl/perceptron_mac.sv
// rtl/perceptron_mac.sv - serial accumulator and input index counter (clear/step/done)
module perceptron_mac #(
  parameter int N     = 7,
  parameter int W     = 8,
  parameter int ACC_W = 12,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic signed [ACC_W-1:0] init_i,
  input  logic                    step_i,
  input  logic                    add_en_i,
  input  logic signed [W-1:0]     addend_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    done_o
);
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (clear_i) begin
      acc_d = init_i;
      idx_d = '0;
    end else if (step_i) begin
      if (add_en_i) begin
        acc_d = acc_q + ACC_W'(addend_i);
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

  assign acc_o  = acc_q;
  assign idx_o  = idx_q;
  assign done_o = (idx_q == IDX_W'(N - 1));
endmodule

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - serial perceptron with online learning; PERCEPTRON_BIAS_EN adds a learnable bias
module perceptron_trainer import perceptron_pkg::*; #(
  parameter int N     = 7,
  parameter int W     = 8,
  parameter int ACC_W = 12,
  parameter int LR    = 1,
  parameter int ERR_W = 16
) (
  input logic clk,
  input logic reset,
  perceptron_trainer_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  if (ACC_W < W + $clog2(N)) begin : g_acc_width_chk
    $error("perceptron_trainer: ACC_W too narrow, accumulator could overflow");
  end

  state_t                  state_q, state_d;
  logic [N-1:0]            x_q;
  logic signed [ACC_W-1:0] thr_q;
  logic                    exp_q, train_q;
  logic signed [W-1:0]     w_q [N];
  logic signed [W-1:0]     w_d [N];
  logic [1:0]              result_q, result_d;
  logic                    mis_q, mis_d;
  logic [ERR_W-1:0]        err_q, err_d, err_dec;
  logic                    accept;
  logic [1:0]              res_c;
  logic                    mis_c;
  logic signed [31:0]      step_c;
  logic                    mac_clear, mac_step, mac_done;
  logic signed [ACC_W-1:0] mac_init, acc;
  logic [IDX_W-1:0]        idx;

`ifdef PERCEPTRON_BIAS_EN
  logic signed [W-1:0] b_q, b_d;
  assign mac_init = ACC_W'(b_q);
`else
  assign mac_init = '0;
`endif

  perceptron_mac #(.N(N), .W(W), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear_i (mac_clear),
    .init_i  (mac_init),
    .step_i  (mac_step),
    .add_en_i(state_q == ACCUM && x_q[idx]),
    .addend_i(w_q[idx]),
    .acc_o   (acc),
    .idx_o   (idx),
    .done_o  (mac_done)
  );

  assign bus.in_ready = (state_q == IDLE) && !bus.clear_w;
  assign accept       = bus.in_valid && bus.in_ready;
  assign res_c        = (acc >= thr_q) ? RES_POS : RES_NEG;
  assign mis_c        = (res_c == RES_POS) != exp_q;
  assign err_dec      = (mis_c && err_q != '1) ? err_q + ERR_W'(1) : err_q;
  assign step_c       = exp_q ? 32'(LR) : -32'(LR);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    result_d  = result_q;
    mis_d     = mis_q;
    err_d     = err_q;
    mac_clear = 1'b0;
    mac_step  = 1'b0;
`ifdef PERCEPTRON_BIAS_EN
    b_d = b_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.clear_w) begin
          w_d   = '{default: '0};
          err_d = '0;
`ifdef PERCEPTRON_BIAS_EN
          b_d = '0;
`endif
        end else if (accept) begin
          mac_clear = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        mac_step = 1'b1;
        if (mac_done) state_d = DECIDE;
      end
      DECIDE: begin
        result_d = res_c;
        mis_d    = mis_c;
        err_d    = err_dec;
        // Reuse the index counter for the weight walk; acc is no longer needed.
        if (train_q && mis_c) begin
          mac_clear = 1'b1;
          state_d   = UPDATE;
        end else begin
          state_d = IDLE;
        end
      end
      UPDATE: begin
        mac_step = 1'b1;
        if (x_q[idx]) w_d[idx] = W'(sat_add(32'(w_q[idx]), step_c, W));
`ifdef PERCEPTRON_BIAS_EN
        if (idx == '0) b_d = W'(sat_add(32'(b_q), step_c, W));
`endif
        if (mac_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      thr_q    <= '0;
      exp_q    <= 1'b0;
      train_q  <= 1'b0;
      w_q      <= '{default: '0};
      result_q <= 2'b00;
      mis_q    <= 1'b0;
      err_q    <= '0;
`ifdef PERCEPTRON_BIAS_EN
      b_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      result_q <= result_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
`ifdef PERCEPTRON_BIAS_EN
      b_q <= b_d;
`endif
      if (accept) begin
        x_q     <= bus.x;
        thr_q   <= bus.threshold;
        exp_q   <= bus.exp_res;
        train_q <= bus.train_en;
      end
    end
  end

  // The decision is visible combinationally during its DECIDE cycle, then held.
  assign bus.out_valid  = (state_q == DECIDE);
  assign bus.result     = bus.out_valid ? res_c : result_q;
  assign bus.mispredict = bus.out_valid ? mis_c : mis_q;
  assign bus.err_count  = bus.out_valid ? err_dec : err_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - scoreboard bench for perceptron_trainer (also runs with PERCEPTRON_BIAS_EN)
module tb_perceptron_trainer;
  localparam int N     = 7;
  localparam int W     = 8;
  localparam int ACC_W = 12;
  localparam int LR    = 1;
  localparam int ERR_W = 16;

  typedef struct {
    logic signed [ACC_W-1:0] acc;
    logic [1:0]              res;
    logic                    mis;
    logic [ERR_W-1:0]        err;
    int                      ready_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   mw[N];
  int   mb;
  int   merr;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  perceptron_trainer_if #(.N(N), .ACC_W(ACC_W), .ERR_W(ERR_W)) bus ();

  perceptron_trainer #(.N(N), .W(W), .ACC_W(ACC_W), .LR(LR), .ERR_W(ERR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic int msat(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) mw[i] = 0;
    mb   = 0;
    merr = 0;
  endfunction

  task automatic model_push(input logic [N-1:0] x, input int thr, input logic e, input logic tr);
    exp_t t;
    int   a;
    a = mb;
    for (int i = 0; i < N; i++) if (x[i]) a += mw[i];
    t.acc = ACC_W'(a);
    t.res = (a >= thr) ? 2'b01 : 2'b11;
    t.mis = (t.res == 2'b01) != e;
    if (t.mis && merr < (1 << ERR_W) - 1) merr++;
    t.err       = ERR_W'(merr);
    t.ready_lat = (tr && t.mis) ? 2 * N + 2 : N + 2;
    if (tr && t.mis) begin
      for (int i = 0; i < N; i++) if (x[i]) mw[i] = msat(mw[i] + (e ? LR : -LR));
`ifdef PERCEPTRON_BIAS_EN
      mb = msat(mb + (e ? LR : -LR));
`endif
    end
    sb.push_back(t);
  endtask

  task automatic start_sample(input logic [N-1:0] x, input int thr, input logic e, input logic tr);
    for (int k = 0; k < 100 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_wait: in_ready=%b required 1", bus.in_ready);
    else passed++;
    bus.x         = x;
    bus.threshold = ACC_W'(thr);
    bus.exp_res   = e;
    bus.train_en  = tr;
    bus.in_valid  = 1'b1;
    model_push(x, thr, e, tr);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_sample();
    exp_t e;
    int   cnt;
    cnt = 1;
    while (!bus.out_valid && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (!bus.out_valid || sb.size() == 0) begin
      $display("FAIL out_valid_timeout: waited %0d cycles, queue=%0d", cnt, sb.size());
      return;
    end
    passed++;
    e = sb.pop_front();
    total++;
    if (cnt !== N + 1) $display("FAIL latency: got %0d cycles required %0d", cnt, N + 1);
    else passed++;
    total++;
    if (dut.u_mac.acc_o !== e.acc) $display("FAIL acc: got %0d required %0d", dut.u_mac.acc_o, e.acc);
    else passed++;
    total++;
    if (bus.result !== e.res) $display("FAIL result: got %b required %b", bus.result, e.res);
    else passed++;
    total++;
    if (bus.mispredict !== e.mis) $display("FAIL mispredict: got %b required %b", bus.mispredict, e.mis);
    else passed++;
    total++;
    if (bus.err_count !== e.err) $display("FAIL err_count: got %0d required %0d", bus.err_count, e.err);
    else passed++;
    @(posedge clk); #1;
    cnt++;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL out_valid_pulse: got %b required 0", bus.out_valid);
    else passed++;
    while (!bus.in_ready && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt !== e.ready_lat) $display("FAIL ready_latency: got %0d required %0d", cnt, e.ready_lat);
    else passed++;
  endtask

  task automatic run_sample(input logic [N-1:0] x, input int thr, input logic e, input logic tr);
    start_sample(x, thr, e, tr);
    finish_sample();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.threshold = '0;
    bus.exp_res  = 1'b0;
    bus.train_en = 1'b0;
    bus.clear_w  = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    else passed++;
    total++;
    if (bus.result !== 2'b00 || bus.mispredict !== 1'b0 || bus.err_count !== '0)
      $display("FAIL reset_out: result=%b mis=%b err=%0d required 00/0/0", bus.result, bus.mispredict, bus.err_count);
    else passed++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.w_q[i] !== W'(mw[i])) $display("FAIL reset_w%0d: got %0d required %0d", i, dut.w_q[i], mw[i]);
      else passed++;
    end
  endtask

  task automatic test_basic();
    run_sample(7'h7F, 0, 1'b1, 1'b0);
    run_sample(7'h2A, -1, 1'b0, 1'b0);
  endtask

  task automatic test_train();
    run_sample(7'h7F, 1, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.w_q[i] !== W'(mw[i])) $display("FAIL train_w%0d: got %0d required %0d", i, dut.w_q[i], mw[i]);
      else passed++;
    end
    run_sample(7'h7F, 1, 1'b1, 1'b1);
    run_sample(7'h55, 4, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 200; n++) run_sample(7'h01, -200, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.w_q[i] !== W'(mw[i])) $display("FAIL sat_w%0d: got %0d required %0d", i, dut.w_q[i], mw[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_update();
    int seen;
    start_sample(7'h7F, 1000, 1'b1, 1'b1);
    for (int k = 0; k < 60 && !bus.out_valid; k++) begin
      @(posedge clk); #1;
    end
    void'(sb.pop_front());
    repeat (3) begin
      @(posedge clk); #1;
    end
    seen  = 0;
    reset = 1'b1;
    #1 if (bus.out_valid) seen++;
    @(posedge clk); #1;
    if (bus.out_valid) seen++;
    reset = 1'b0;
    model_clear();
    #1 if (bus.out_valid) seen++;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b required 1", bus.in_ready);
    else passed++;
    repeat (N + 2) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL rst_mid_outvalid: got %0d pulses required 0", seen);
    else passed++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.w_q[i] !== W'(mw[i])) $display("FAIL rst_mid_w%0d: got %0d required %0d", i, dut.w_q[i], mw[i]);
      else passed++;
    end
  endtask

  task automatic test_clear_w();
    run_sample(7'h7F, 1, 1'b1, 1'b1);
    bus.clear_w   = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x         = 7'h7F;
    bus.threshold = ACC_W'(1);
    bus.exp_res   = 1'b1;
    bus.train_en  = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL clear_ready: got %b required 0", bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    model_clear();
    total++;
    if (bus.err_count !== '0 || bus.out_valid !== 1'b0)
      $display("FAIL clear_err: err=%0d out_valid=%b required 0/0", bus.err_count, bus.out_valid);
    else passed++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (dut.w_q[i] !== W'(mw[i])) $display("FAIL clear_w%0d: got %0d required %0d", i, dut.w_q[i], mw[i]);
      else passed++;
    end
    bus.clear_w = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL clear_release: in_ready=%b required 1", bus.in_ready);
    else passed++;
    run_sample(7'h7F, 1, 1'b1, 1'b0);
  endtask

`ifdef PERCEPTRON_BIAS_EN
  task automatic test_bias();
    run_sample(7'h00, 1, 1'b1, 1'b1);
    total++;
    if (dut.b_q !== W'(mb)) $display("FAIL bias_value: got %0d required %0d", dut.b_q, mb);
    else passed++;
    run_sample(7'h00, 1, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_train();
    test_saturation();
    test_reset_mid_update();
    test_clear_w();
`ifdef PERCEPTRON_BIAS_EN
    test_bias();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Parametrised successor to the single-cycle perceptron: N binary inputs, W-bit signed weights, serial multiply-accumulate (one input per cycle) and an online perceptron learning rule.
- Sits behind the top-level IO mux. Each sample is accepted through a valid/ready handshake. The block returns a ±1 classification and, when training is enabled, updates its weights.
- Keeps a saturating misclassification counter for on-chip accuracy readout.

Parameters:
- N, 7, number of perceptron inputs (2..16)
- W, 8, weight width, two's complement
- ACC_W, 12, accumulator/threshold width, signed, must be >= W + clog2(N)
- LR, 1, learning-rate step added to or subtracted from a weight (1..2^(W-2))
- ERR_W, 16, error-counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- x  in  N  binary perceptron inputs
- threshold  in  ACC_W  signed activation threshold
- exp_res  in  1  expected class: 1 = +1, 0 = -1
- train_en  in  1  apply learning rule to this sample
- clear_w  in  1  synchronous weight/counter clear, honoured only in IDLE
- out_valid  out  1  one-cycle pulse, result valid
- result  out  2  2'b01 = +1, 2'b11 = -1
- mispredict  out  1  result != exp_res, valid with out_valid
- err_count  out  ERR_W  saturating count of mispredictions

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on port reset.
- Reset values:
  - state IDLE
  - all weights 0, accumulator 0, index 0
  - in_ready 1, out_valid 0, result 2'b00, mispredict 0, err_count 0
- Reset asserted mid-operation aborts immediately. Partially updated weights are cleared; no out_valid is produced.
- FSM states: IDLE, ACCUM, DECIDE, UPDATE.
- IDLE:
  - in_ready = 1.
  - clear_w=1 zeroes all weights and err_count in one cycle. While clear_w=1, in_ready = 0 and the sample is not accepted.
  - On in_valid & in_ready: latch x, threshold, exp_res and train_en; clear acc and idx; go to ACCUM.
- ACCUM:
  - Each cycle: if x[idx], add sign-extended w[idx] to acc; then idx++.
  - After idx = N-1, go to DECIDE. ACCUM lasts exactly N cycles.
- DECIDE (1 cycle):
  - result = (acc >= threshold, signed compare) ? 2'b01 : 2'b11.
  - out_valid = 1 and mispredict updated in this cycle.
  - On a mispredict, err_count increments and saturates at all-ones.
  - If train_en & mispredict, go to UPDATE with idx = 0; else go to IDLE.
- UPDATE (N cycles):
  - If x[idx], w[idx] += (exp_res ? +LR : -LR), saturating to [-2^(W-1), 2^(W-1)-1]. Then idx++.
  - After idx = N-1, go to IDLE.
- Latency: out_valid asserts N+1 cycles after the accepting edge.
- Throughput:
  - Correct or non-training sample: one per N+2 cycles.
  - Training mispredict: one per 2N+2 cycles.
- in_ready = 0 in every non-IDLE state; in_valid is ignored there.
- result, mispredict and err_count hold their values until the next DECIDE.
- Accumulator cannot overflow given the ACC_W constraint; the implementation checks this with an elaboration-time assertion.

Optional Feature:
- Macro: PERCEPTRON_BIAS_EN.
- Defined:
  - Adds a learnable W-bit bias weight b.
  - The accumulator is initialised to sign-extended b instead of 0 on acceptance. Latency is unchanged.
  - In UPDATE, b += ±LR (saturating) on the first UPDATE cycle, alongside w[0].
  - b is reset and cleared with the weights.
- Undefined: no bias register; the accumulator starts at 0.

Decomposition:
- Package perceptron_pkg:
  - state enum
  - result encodings RES_POS = 2'b01, RES_NEG = 2'b11
  - saturating-add function for W-bit signed values
- Sub-module perceptron_mac: accumulator and index counter (clear/step/done). The FSM and weight file stay in the top module.

Test Plan (N=7, W=8, ACC_W=12, LR=1):
- Reset, then x=7'h7F, threshold=0, train_en=0 -> out_valid exactly 8 cycles after accept; acc=0; result=2'b01; err_count=0.
- Same sample with threshold=1, exp_res=1, train_en=1 -> result=2'b11, mispredict=1, err_count=1. After 7 UPDATE cycles all w=+1; in_ready returns after 16 cycles total. Repeat -> acc=7, result=2'b01, mispredict=0.
- x=7'h01, exp_res=0, threshold=-200, train_en=1 repeated 200 times -> w[0] saturates at -128 and never wraps; other weights unchanged.
- Assert reset for 1 cycle during UPDATE -> out_valid stays 0; all weights 0; in_ready=1 in the next cycle.
- clear_w=1 with in_valid=1 in IDLE -> sample not accepted; weights and err_count zeroed. Drop clear_w -> sample accepted in the next cycle.
- With PERCEPTRON_BIAS_EN defined: x=0, threshold=1, exp_res=1, train_en=1, twice -> first sample mispredicts and b=1; second gives result=2'b01.
